// File: rtl/fruta_gen_if.sv
// Fruit-request and tile-map read bundle between the game update FSM, the shared map and fruta_gen.
interface fruta_gen_if;
  logic       fruta_enable;
  logic       fruta_wenable;
  logic [9:0] fruta_wx;
  logic [9:0] fruta_wy;
  logic       map_renable;
  logic [9:0] map_rx;
  logic [9:0] map_ry;
  logic [1:0] map_rdata;
  logic       busy;

  modport master (
    output fruta_enable, map_rdata,
    input  fruta_wenable, fruta_wx, fruta_wy, map_renable, map_rx, map_ry, busy
  );

  modport slave (
    input  fruta_enable, map_rdata,
    output fruta_wenable, fruta_wx, fruta_wy, map_renable, map_rx, map_ry, busy
  );
endinterface

// File: rtl/fruta_gen.sv
// Fruit position generator: keeps a revalidated empty map cell ready, searching by LFSR
// candidates first and falling back to a raster scan of the whole map.
module fruta_gen #(
  parameter int          MAPA_WIDTH  = 40,
  parameter int          MAPA_HEIGHT = 30,
  parameter int          MAX_TRIES   = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic        clk,
  input logic        reset,
  fruta_gen_if.slave bus
);

  localparam logic [9:0]          MAP_W     = 10'(MAPA_WIDTH);
  localparam logic [9:0]          MAP_H     = 10'(MAPA_HEIGHT);
  localparam int                  TRIES_W   = $clog2(MAX_TRIES + 1);
  localparam logic [TRIES_W-1:0]  LAST_TRY  = TRIES_W'(MAX_TRIES - 1);
  localparam int                  CELLS     = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int                  SCAN_W    = $clog2(CELLS + 1);
  localparam logic [SCAN_W-1:0]   LAST_CELL = SCAN_W'(CELLS - 1);

  typedef enum logic [2:0] {
    GEN, RD, CHK, SCAN_RD, SCAN_CHK, HOLD_RD, HOLD, FULL
  } state_t;

  state_t              state, state_nxt;
  logic [15:0]         lfsr, lfsr_nxt, lfsr_step;
  logic [9:0]          cx, cy, cx_nxt, cy_nxt, step_x, step_y;
  logic [9:0]          sx, sy, sx_nxt, sy_nxt;
  logic [9:0]          wx, wy, wx_nxt, wy_nxt;
  logic [TRIES_W-1:0]  tries, tries_nxt;
  logic [SCAN_W-1:0]   scan_cnt, scan_cnt_nxt;
  logic                wen, wen_nxt;
  logic                busy_q, busy_nxt;
  logic                cell_free;

  // x^16+x^14+x^13+x^11+1, shifted left with the feedback entering bit 0.
  assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign step_x    = {4'd0, lfsr_step[5:0]};
  assign step_y    = {5'd0, lfsr_step[12:8]};
  assign cell_free = (bus.map_rdata == 2'b00);

  // NOTE: every next-state value gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    lfsr_nxt     = lfsr;
    cx_nxt       = cx;
    cy_nxt       = cy;
    sx_nxt       = sx;
    sy_nxt       = sy;
    wx_nxt       = wx;
    wy_nxt       = wy;
    tries_nxt    = tries;
    scan_cnt_nxt = scan_cnt;
    wen_nxt      = wen;

    case (state)
      GEN: begin
        lfsr_nxt = lfsr_step;
        cx_nxt   = step_x;
        cy_nxt   = step_y;
        if (step_x < MAP_W && step_y < MAP_H) state_nxt = RD;
      end

      RD: state_nxt = CHK;

      CHK: begin
        // The held cell is excluded so a consumed position is never handed out again.
        if (cell_free && {cx, cy} != {wx, wy}) begin
          wx_nxt    = cx;
          wy_nxt    = cy;
          wen_nxt   = 1'b1;
          tries_nxt = '0;
          state_nxt = HOLD_RD;
        end else if (tries == LAST_TRY) begin
          tries_nxt    = '0;
          sx_nxt       = cx;
          sy_nxt       = cy;
          scan_cnt_nxt = '0;
          state_nxt    = SCAN_RD;
        end else begin
          tries_nxt = tries + TRIES_W'(1);
          state_nxt = GEN;
        end
      end

      SCAN_RD: state_nxt = SCAN_CHK;

      SCAN_CHK: begin
        if (cell_free && {sx, sy} != {wx, wy}) begin
          wx_nxt    = sx;
          wy_nxt    = sy;
          wen_nxt   = 1'b1;
          state_nxt = HOLD_RD;
        end else if (scan_cnt == LAST_CELL) begin
          wen_nxt   = 1'b0;
          state_nxt = FULL;
        end else begin
          scan_cnt_nxt = scan_cnt + SCAN_W'(1);
          state_nxt    = SCAN_RD;
          if (sx == MAP_W - 10'd1) begin
            sx_nxt = '0;
            sy_nxt = (sy == MAP_H - 10'd1) ? '0 : sy + 10'd1;
          end else begin
            sx_nxt = sx + 10'd1;
          end
        end
      end

      HOLD_RD: begin
        if (bus.fruta_enable) begin
          wen_nxt   = 1'b0;
          state_nxt = GEN;
        end else begin
          state_nxt = HOLD;
        end
      end

      HOLD: begin
        // A consume request and an occupied held cell lead to the same restart.
        if (bus.fruta_enable || !cell_free) begin
          wen_nxt   = 1'b0;
          state_nxt = GEN;
        end else begin
          state_nxt = HOLD_RD;
        end
      end

      FULL: begin
        if (bus.fruta_enable) begin
          tries_nxt = '0;
          state_nxt = GEN;
        end
      end

      default: state_nxt = GEN;
    endcase

    busy_nxt = state_nxt inside {GEN, RD, CHK, SCAN_RD, SCAN_CHK};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= GEN;
      lfsr     <= LFSR_SEED;
      cx       <= '0;
      cy       <= '0;
      sx       <= '0;
      sy       <= '0;
      wx       <= '0;
      wy       <= '0;
      tries    <= '0;
      scan_cnt <= '0;
      wen      <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lfsr     <= lfsr_nxt;
      cx       <= cx_nxt;
      cy       <= cy_nxt;
      sx       <= sx_nxt;
      sy       <= sy_nxt;
      wx       <= wx_nxt;
      wy       <= wy_nxt;
      tries    <= tries_nxt;
      scan_cnt <= scan_cnt_nxt;
      wen      <= wen_nxt;
      busy_q   <= busy_nxt;
    end
  end

  always_comb begin
    bus.map_renable = 1'b0;
    bus.map_rx      = '0;
    bus.map_ry      = '0;
    case (state)
      RD: begin
        bus.map_renable = 1'b1;
        bus.map_rx      = cx;
        bus.map_ry      = cy;
      end
      SCAN_RD: begin
        bus.map_renable = 1'b1;
        bus.map_rx      = sx;
        bus.map_ry      = sy;
      end
      HOLD_RD: begin
        bus.map_renable = 1'b1;
        bus.map_rx      = wx;
        bus.map_ry      = wy;
      end
      default: ;
    endcase
  end

  assign bus.fruta_wenable = wen;
  assign bus.fruta_wx      = wx;
  assign bus.fruta_wy      = wy;
  assign bus.busy          = busy_q;

endmodule

// File: doc/fruta_gen.md
Name: fruta_gen

Overview:
- Responder side of the fruit-request interface driven by the game update FSM.
- Keeps a pre-validated empty map cell on fruta_wx/fruta_wy at all times. When the update FSM pulses fruta_enable, that cell is consumed and a new one is searched for.
- Finds empty cells by reading the shared 2-bit tile map through its own read port. Encoding: 00 empty, 01 snake, 10 fruit, 11 obstacle.

Parameters:
- MAPA_WIDTH, 40, map columns (≤64)
- MAPA_HEIGHT, 30, map rows (≤32)
- MAX_TRIES, 64, random candidates rejected for occupancy before falling back to raster scan
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fruta_enable  in  1  one-cycle request pulse: held position is being consumed
- fruta_wenable  out  1  level: fruta_wx/fruta_wy hold a validated empty cell
- fruta_wx  out  10  held fruit column
- fruta_wy  out  10  held fruit row
- map_renable  out  1  map read strobe
- map_rx  out  10  read column
- map_ry  out  10  read row
- map_rdata  in  2  read data, valid the cycle after map_renable
- busy  out  1  high in any search state (GEN, RD, CHK, SCAN_RD, SCAN_CHK)

Behaviour:
- Reset (asynchronous, while reset==0): fruta_wenable=0, fruta_wx=0, fruta_wy=0, map_renable=0, map_rx=0, map_ry=0, busy=0, lfsr=LFSR_SEED, tries=0, state=GEN.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shift left, feedback into bit0. Steps exactly once per GEN cycle.
- Candidate: cx=lfsr[5:0], cy=lfsr[12:8], zero-extended to 10 bits.
- GEN: step LFSR and form the candidate.
  - If cx≥MAPA_WIDTH or cy≥MAPA_HEIGHT, stay in GEN. This is a range reject and does not count toward tries.
  - Otherwise go to RD.
- RD: map_renable=1, map_rx=cx, map_ry=cy. Go to CHK.
- CHK: evaluate map_rdata. map_renable=0 in every state except RD, SCAN_RD and HOLD_RD.
  - Accept if map_rdata==00 AND (cx,cy)≠(fruta_wx,fruta_wy). On accept: fruta_wx=cx, fruta_wy=cy, fruta_wenable=1, tries=0, go to HOLD.
  - Otherwise: tries+=1. If tries reaches MAX_TRIES, go to SCAN_RD with scan pointer = (cx,cy); else go to GEN.
- SCAN_RD / SCAN_CHK: same 2-cycle read/check applied to the scan pointer, with the same accept rule.
  - Pointer advances raster order: x+1; at MAPA_WIDTH, x=0 and y+1; at MAPA_HEIGHT, y=0.
  - After MAPA_WIDTH*MAPA_HEIGHT rejected cells, go to FULL.
- FULL: fruta_wenable=0, busy=0, no reads. Next fruta_enable goes to GEN with tries=0.
- HOLD: revalidation loop, 2 cycles per check.
  - HOLD_RD reads (fruta_wx,fruta_wy).
  - HOLD checks the read. If map_rdata≠00, fruta_wenable=0 and go to GEN. This covers the snake or the map-init sweep landing on the held cell.
- fruta_enable in HOLD or HOLD_RD: fruta_wenable=0 on the next edge, go to GEN.
  - fruta_wx/fruta_wy keep their value; they change only on an accept.
  - The earliest output change is therefore ≥3 cycles after the request, which guarantees stability in the cycle the consumer samples.
- fruta_enable during a search: ignored. The search continues; the consumer has already taken the stale held value.
- fruta_enable and a revalidation fail in the same cycle: result is GEN with fruta_wenable=0 (identical outcome).
- A reset asserted mid-search aborts immediately. The search restarts from LFSR_SEED, so the candidate sequence is deterministic.

Test Plan:
- Reset, then all-empty map model (1-cycle read latency) -> fruta_wenable rises at the first in-range LFSR candidate after the seed; coordinates match the bench LFSR model; fruta_wx<40, fruta_wy<30.
- Map model returns 01 for the first 3 in-range candidates -> those 3 are rejected; the 4th is accepted; tries resets to 0.
- In HOLD, flip the held cell to 10 -> fruta_wenable falls within 2 cycles; a new, different cell is accepted.
- Pulse fruta_enable in HOLD -> fruta_wenable=0 next cycle; fruta_wx/wy unchanged for ≥2 cycles after the pulse, then a new cell different from the old one.
- Map all 01 except (39,29); MAX_TRIES=4 -> after 4 rejects, raster scan finds (39,29), including wrap from the start point. Map entirely 01 -> FULL after 1200 scan reads, busy=0, fruta_wenable=0.
- Drive reset=0 mid-scan, asynchronously between clock edges -> all outputs go to reset values immediately; after release, the candidate sequence repeats the first test exactly.
